instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage directly upstream of the CPU datapath. It owns the fetch PC and issues
//  one-at-a-time word reads to a variable-latency instruction memory.
//  Returned words are buffered with their PC in a small queue, which presents Instr to
//  the CPU over a valid/ready handshake. Branch/jump redirects flush the queue and
//  discard any in-flight response.
// PARAMETERS
//  DEPTH     4             queue entries (power of two, >=2)
//  RESET_PC  32'h00000000  fetch PC after reset (low 2 bits must be 0)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  Reset           in   1   synchronous, active-high reset
//  redirect_valid  in   1   CPU taken branch/jump this cycle
//  redirect_pc     in   32  new fetch PC; bits[1:0] ignored (forced 0)
//  instr_ready     in   1   CPU consumes head entry this cycle
//  instr_valid     out  1   head entry valid (queue not empty)
//  Instr           out  32  head instruction; 32'h00000013 (NOP) when empty
//  instr_pc        out  32  PC of head instruction; 0 when empty
//  mem_req         out  1   one-cycle pulse: read request to instruction memory
//  mem_addr        out  32  request address, word aligned; held until response
//  mem_rvalid      in   1   response valid (>=1 cycle after mem_req)
//  mem_rdata       in   32  response word
// BEHAVIOUR
//  - Reset: count=0, state IDLE, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC,
//    instr_valid=0. Reset mid-WAIT drops the request; late responses are ignored.
//  - FSM IDLE/WAIT/DISCARD. At most one outstanding request.
//  - Space: can_issue = (count - pop) < DEPTH-1 when a push occurs this cycle;
//    otherwise (count - pop) < DEPTH. An issued request therefore always has a slot.
//  - IDLE: if can_issue && !redirect_valid -> mem_req=1, mem_addr=fetch_pc, go WAIT.
//  - WAIT: if mem_rvalid -> push {mem_addr, mem_rdata}, fetch_pc+=4. Then if can_issue,
//    issue fetch_pc+4 the same cycle (stay WAIT); else go IDLE.
//    Without mem_rvalid, stay WAIT with mem_addr stable.
//  - DISCARD: wait for mem_rvalid, drop the data, go IDLE. No push, no issue.
//  - mem_rvalid in IDLE: ignored.
//  - Redirect (highest priority, any state):
//    - count<=0; pop and push suppressed; fetch_pc<={redirect_pc[31:2],2'b0}.
//    - No mem_req in the redirect cycle.
//    - WAIT without same-cycle rvalid -> DISCARD; WAIT with rvalid -> data dropped,
//      go IDLE.
//    - Redirect in DISCARD stays DISCARD with the newest PC.
//  - Pop = instr_valid && instr_ready. Simultaneous push and pop on a full queue is legal
//    (count unchanged). Pop when empty is ignored.
//  - Outputs Instr/instr_pc/instr_valid come combinationally from registered queue state
//    (no input->output comb path).
//  - Latency: mem_rvalid at cycle N -> instr_valid at N+1. Best throughput is
//    1 instruction/cycle with a 1-cycle memory.
//  - fetch_pc wraps from 32'hFFFFFFFC to 0 silently. Pointers wrap modulo DEPTH.
// STRUCTURE
//  - fetch_pkg:
//    - typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t
//    - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
//    - localparam NOP_INSTR = 32'h00000013
//  - Sub-module fetch_fifo #(DEPTH, fetch_entry_t): push/pop/flush, count, head out.
//    The top holds the FSM and fetch_pc.
// TESTING
//  1. Reset 2 cycles, 1-cycle mem returning 00C00193/00700393/0471AA23/06002103, ready=1
//     -> mem_addr 0,4,8,C on consecutive cycles; Instr in order, instr_pc 0,4,8,C.
//  2. ready=0, 1-cycle mem -> exactly 4 requests, instr_valid=1, mem_req then stays 0.
//     Raise ready -> one refill request per pop, no overflow or loss.
//  3. 3-cycle mem latency; redirect_pc=32'h40 one cycle after mem_req(0) -> stale word
//     dropped, next mem_addr=32'h40, first Instr has instr_pc=32'h40.
//  4. redirect_pc=32'h103 with queue holding 3 entries -> instr_valid=0 next cycle,
//     mem_addr=32'h100.
//  5. redirect coincident with mem_rvalid -> word not pushed, state IDLE,
//     next mem_req at new PC.
//  6. Reset asserted mid-WAIT, response arrives after reset -> ignored,
//     first request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: FSM states,
// queue entry layout and the NOP returned when the queue is empty.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the CPU-side (redirect, instruction handshake) and memory-side
// signals of the fetch stage; master is the fetch unit, slave its environment.
interface instr_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  redirect_valid, redirect_pc, instr_ready, mem_rvalid, mem_rdata,
        output instr_valid, Instr, instr_pc, mem_req, mem_addr
    );

    modport slave (
        output redirect_valid, redirect_pc, instr_ready, mem_rvalid, mem_rdata,
        input  instr_valid, Instr, instr_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Small circular queue of fetched entries with synchronous flush; the head
// entry is read straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  T                         i_wdata,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one outstanding word read at a time
// and buffers returned words with their PC for the CPU; redirects flush everything.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   Reset,
    instr_fetch_queue_if.master    bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state, w_state_next;
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic [31:0]   r_mem_addr, w_mem_addr_next;
    logic [31:0]   w_issue_addr;
    logic          w_issue, w_req, w_push, w_pop, w_valid;
    logic          w_room, w_room_push;
    logic [CW-1:0] w_count, w_after_pop;
    fetch_entry_t  w_head, w_wdata;

    assign w_valid     = (w_count != '0);
    assign w_pop       = w_valid && bus.instr_ready && !bus.redirect_valid;
    assign w_after_pop = w_count - {{(CW-1){1'b0}}, w_pop};
    // A request issued alongside a push must still find a free slot when it returns.
    assign w_room      = w_after_pop < CW'(DEPTH);
    assign w_room_push = w_after_pop < CW'(DEPTH - 1);

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_issue         = 1'b0;
        w_issue_addr    = r_fetch_pc;
        w_push          = 1'b0;
        if (bus.redirect_valid) begin
            w_fetch_pc_next = word_align(bus.redirect_pc);
            case (r_state)
                WAIT:    w_state_next = bus.mem_rvalid ? IDLE : DISCARD;
                // The outstanding response retires here, so nothing is left to wait for.
                DISCARD: w_state_next = bus.mem_rvalid ? IDLE : DISCARD;
                default: w_state_next = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_room) begin
                        w_issue      = 1'b1;
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        w_push          = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                        w_issue_addr    = r_fetch_pc + 32'd4;
                        if (w_room_push) begin
                            w_issue = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.mem_rvalid) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign w_req           = w_issue && !Reset;
    assign w_mem_addr_next = w_req ? w_issue_addr : r_mem_addr;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    assign w_wdata = '{pc: r_mem_addr, instr: bus.mem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .srst    (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign bus.instr_valid = w_valid;
    assign bus.Instr       = w_valid ? w_head.instr : NOP_INSTR;
    assign bus.instr_pc    = w_valid ? w_head.pc : 32'h0;
    assign bus.mem_req     = w_req;
    assign bus.mem_addr    = w_mem_addr_next;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: variable-latency memory model,
// budget-driven consumer and a monitor that checks every accepted instruction.
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           budget  = 0;
    int           lat     = 1;
    int           cyc     = 0;
    fetch_entry_t sb_q[$];
    logic [31:0]  req_addr_q[$];
    int           req_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00C00193;
            32'h4:   return 32'h00700393;
            32'h8:   return 32'h0471AA23;
            32'hC:   return 32'h06002103;
            default: return 32'hB000_0000 | a;
        endcase
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_addr_q.size()) return req_addr_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end else begin
            $display("[TB] %s = %h", name, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    task automatic start_test(input int lat_v);
        Reset                = 1'b1;
        budget               = 0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = 32'h0;
        lat                  = lat_v;
        tick(2);
        req_addr_q.delete();
        req_cyc_q.delete();
        Reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        tick(20);
    endtask

    // Memory: one outstanding read, response lat cycles after the request cycle.
    initial begin : mem_model
        logic        req;
        logic [31:0] addr;
        logic [31:0] paddr;
        int          cnt;
        bit          pend;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 32'h0;
        forever begin
            @(negedge clk);
            req  = bus.mem_req;
            addr = bus.mem_addr;
            if (req) begin
                req_addr_q.push_back(addr);
                req_cyc_q.push_back(cyc);
            end
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            if (req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = addr;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(paddr);
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin : consumer
        bus.instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.instr_ready = (budget > 0);
        end
    end

    initial begin : monitor
        fetch_entry_t exp_e;
        forever begin
            @(negedge clk);
            if (!Reset && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                budget--;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc=%h instr=%h required no instruction",
                             bus.instr_pc, bus.Instr);
                end else begin
                    exp_e = sb_q.pop_front();
                    if (bus.instr_pc !== exp_e.pc || bus.Instr !== exp_e.instr) begin
                        n_fail++;
                        $display("FAIL pop: got pc=%h instr=%h required pc=%h instr=%h",
                                 bus.instr_pc, bus.Instr, exp_e.pc, exp_e.instr);
                    end else begin
                        $display("[TB] pop pc=%h instr=%h", bus.instr_pc, bus.Instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int dc;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // 1: reset state, then back-to-back fetch with a 1-cycle memory
        Reset = 1'b1;
        lat   = 1;
        tick(1);
        @(negedge clk);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_Instr", bus.Instr, 32'h00000013);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        tick(1);
        req_addr_q.delete();
        req_cyc_q.delete();
        Reset  = 1'b0;
        budget = 4;
        expect_entry(32'h0, 32'h00C00193);
        expect_entry(32'h4, 32'h00700393);
        expect_entry(32'h8, 32'h0471AA23);
        expect_entry(32'hC, 32'h06002103);
        drain("t1_drain");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_req_addr%0d", i), req_at(i), 32'(4 * i));
            dc = (req_cyc_q.size() > i) ? req_cyc_q[i] - req_cyc_q[0] : -1;
            check($sformatf("t1_req_cyc%0d", i), 32'(dc), 32'(i));
        end

        // 2: stalled consumer fills the queue, then refills one per pop
        start_test(1);
        tick(12);
        @(negedge clk);
        check("t2_req_count", 32'(req_addr_q.size()), 32'd4);
        check("t2_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_mem_req_idle", 32'(bus.mem_req), 32'd0);
        check("t2_head_pc", bus.instr_pc, 32'h0);
        tick(1);
        budget = 6;
        expect_entry(32'h0,  32'h00C00193);
        expect_entry(32'h4,  32'h00700393);
        expect_entry(32'h8,  32'h0471AA23);
        expect_entry(32'hC,  32'h06002103);
        expect_entry(32'h10, 32'hB000_0010);
        expect_entry(32'h14, 32'hB000_0014);
        drain("t2_drain");
        check("t2_req_total", 32'(req_addr_q.size()), 32'd10);

        // 3: redirect while a 3-cycle read is in flight
        start_test(3);
        budget = 1;
        expect_entry(32'h40, 32'hB000_0040);
        tick(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        @(negedge clk);
        check("t3_no_req_on_redirect", 32'(bus.mem_req), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        drain("t3_drain");
        check("t3_req0", req_at(0), 32'h0);
        check("t3_req1", req_at(1), 32'h40);

        // 4: redirect with three entries queued flushes them
        start_test(3);
        tick(10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        @(negedge clk);
        check("t4_valid_before", 32'(bus.instr_valid), 32'd1);
        tick(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_after", 32'(bus.instr_valid), 32'd0);
        check("t4_Instr_after", bus.Instr, 32'h00000013);
        check("t4_pc_after", bus.instr_pc, 32'h0);
        tick(1);
        budget = 1;
        expect_entry(32'h100, 32'hB000_0100);
        drain("t4_drain");
        check("t4_req_redirect", req_at(4), 32'h100);

        // 5: redirect in the same cycle as the response
        start_test(1);
        tick(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        @(negedge clk);
        check("t5_no_req_on_redirect", 32'(bus.mem_req), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_mem_req", 32'(bus.mem_req), 32'd1);
        check("t5_mem_addr", bus.mem_addr, 32'h200);
        tick(1);
        budget = 1;
        expect_entry(32'h200, 32'hB000_0200);
        drain("t5_drain");

        // 6: reset during an outstanding read; the late response must be ignored
        start_test(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        tick(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t6_req_pc80", bus.mem_addr, 32'h80);
        tick(1);
        Reset = 1'b1;
        @(negedge clk);
        check("t6_req_in_reset", 32'(bus.mem_req), 32'd0);
        tick(2);
        Reset = 1'b0;
        @(negedge clk);
        check("t6_valid_stale", 32'(bus.instr_valid), 32'd0);
        check("t6_mem_req", 32'(bus.mem_req), 32'd1);
        check("t6_mem_addr", bus.mem_addr, 32'h0);
        tick(1);
        @(negedge clk);
        check("t6_valid_next", 32'(bus.instr_valid), 32'd0);
        tick(1);
        budget = 1;
        expect_entry(32'h0, 32'h00C00193);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
